usb_tx_serializer: RTL and testbench

- Parametrised next-generation USB transmit serialiser that replaces the fixed 8-bit parallel-to-serial stage.
- Accepts words over a valid/ready handshake into a one-word holding buffer and shifts them out at bit-strobe rate, LSB or MSB first.
- Inserts USB bit-stuffing internally rather than relying on an external halt, and optionally NRZI-encodes the line.
- Sits between the TX packet/CRC logic and the USB line driver; the driver provides EOP and SE0.

---
 rtl/usb_tx_pkg.sv | 20 ++
 rtl/usb_tx_if.sv | 28 ++
 rtl/usb_nrzi_enc.sv | 30 +++
 rtl/usb_tx_serializer.sv | 194 +++++++++++++++++++
 tb/tb_usb_tx_serializer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit serialiser.
// Imported by the interface, the NRZI encoder and the top.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        STUFF,
        TAIL_STUFF
    } ser_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic STUFF_BIT = 1'b0;

    // Width of a counter that must reach lim.
    function automatic int ones_cnt_w(input int lim);
        return (lim < 1) ? 1 : $clog2(lim + 1);
    endfunction

endpackage

// File: rtl/usb_tx_if.sv
// Word handshake between the TX packet logic and the serialiser.
// The master drives data/valid/last; the slave returns ready.
interface usb_tx_if
    import usb_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_last;
    logic                  tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );

endinterface

// File: rtl/usb_nrzi_enc.sv
// Registered NRZI line encoder: a 0 toggles the line, a 1 holds it.
// BYPASS drives the raw bit straight onto the line instead.
module usb_nrzi_enc
    import usb_tx_pkg::*;
#(
    parameter bit BYPASS = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_bit,
    output logic o_line
);

    logic r_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_line <= LINE_IDLE;
        end else if (i_en) begin
            if (BYPASS)
                r_line <= i_bit;
            else
                r_line <= i_bit ? r_line : ~r_line;
        end
    end

    assign o_line = r_line;

endmodule

// File: rtl/usb_tx_serializer.sv
// USB transmit serialiser: one-word holding buffer, shifter,
// internal bit stuffing and optional NRZI on the line output.
module usb_tx_serializer
    import usb_tx_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int STUFF_LIMIT = 6,
    parameter int LSB_FIRST   = 1,
    parameter int NRZI_EN     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_strobe,
    usb_tx_if.slave               tx,
    output logic                  serial_out,
    output logic                  raw_bit,
    output logic                  stuff_active,
    output logic                  busy,
    output logic                  word_done,
    output logic                  underrun,
    output logic [DATA_WIDTH-1:0] prev_parallel
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int OW = ones_cnt_w(STUFF_LIMIT);

    ser_state_t            r_state, w_state;
    logic [DATA_WIDTH-1:0] r_shift, w_shift;
    logic [DATA_WIDTH-1:0] r_cur, w_cur;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] r_prev, w_prev;
    logic [CW-1:0]         r_bcnt, w_bcnt;
    logic [OW-1:0]         r_ones, w_ones;
    logic                  r_last, w_last;
    logic                  r_pend, w_pend;
    logic                  r_hold_last;
    logic                  r_hold_v;
    logic                  r_raw, w_raw;
    logic                  r_stuff, w_stuff;
    logic                  r_wd, w_wd;
    logic                  r_ur, w_ur;
    logic                  w_emit;
    logic                  w_fetch;
    logic                  w_bnd;
    logic                  w_load;
    logic                  w_bit;
    logic                  w_final;
    logic [OW-1:0]         w_inc;

    assign w_load = tx.tx_valid && !r_hold_v;
    assign w_bit  = (LSB_FIRST != 0) ? r_shift[0]
                                     : r_shift[DATA_WIDTH-1];
    assign w_inc  = w_bit ? (r_ones + OW'(1)) : '0;
    assign w_final = (r_bcnt == CW'(DATA_WIDTH - 1));

    always_comb begin
        w_state = r_state;
        w_shift = r_shift;
        w_cur   = r_cur;
        w_last  = r_last;
        w_bcnt  = r_bcnt;
        w_ones  = r_ones;
        w_pend  = r_pend;
        w_prev  = r_prev;
        w_raw   = r_raw;
        w_stuff = r_stuff;
        w_wd    = 1'b0;
        w_ur    = 1'b0;
        w_emit  = 1'b0;
        w_fetch = 1'b0;
        w_bnd   = 1'b0;
        if (bit_strobe) begin
            unique case (r_state)
                IDLE: begin
                    if (r_hold_v) begin
                        w_fetch = 1'b1;
                        w_state = SHIFT;
                    end
                end
                SHIFT: begin
                    w_emit  = 1'b1;
                    w_raw   = w_bit;
                    w_stuff = 1'b0;
                    w_ones  = w_inc;
                    w_bcnt  = r_bcnt + CW'(1);
                    w_pend  = w_final;
                    if (LSB_FIRST != 0)
                        w_shift = r_shift >> 1;
                    else
                        w_shift = r_shift << 1;
                    // Boundary work waits until the stuffed 0 is out.
                    if (w_inc == OW'(STUFF_LIMIT))
                        w_state = (w_final && r_last) ? TAIL_STUFF
                                                      : STUFF;
                    else if (w_final)
                        w_bnd = 1'b1;
                end
                STUFF, TAIL_STUFF: begin
                    w_emit  = 1'b1;
                    w_raw   = STUFF_BIT;
                    w_stuff = 1'b1;
                    w_ones  = '0;
                    if (r_state == TAIL_STUFF) begin
                        w_wd    = 1'b1;
                        w_prev  = r_cur;
                        w_state = IDLE;
                    end else if (r_pend) begin
                        w_bnd = 1'b1;
                    end else begin
                        w_state = SHIFT;
                    end
                end
            endcase
        end
        if (w_bnd) begin
            w_wd   = 1'b1;
            w_prev = r_cur;
            if (r_hold_v) begin
                w_fetch = 1'b1;
                w_state = SHIFT;
            end else begin
                w_state = IDLE;
                w_ones  = '0;
                w_ur    = !r_last;
            end
        end
        if (w_fetch) begin
            w_shift = r_hold;
            w_cur   = r_hold;
            w_last  = r_hold_last;
            w_bcnt  = '0;
            w_pend  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_cur       <= '0;
            r_last      <= 1'b0;
            r_bcnt      <= '0;
            r_ones      <= '0;
            r_pend      <= 1'b0;
            r_prev      <= '0;
            r_raw       <= LINE_IDLE;
            r_stuff     <= 1'b0;
            r_wd        <= 1'b0;
            r_ur        <= 1'b0;
            r_hold      <= '0;
            r_hold_last <= 1'b0;
            r_hold_v    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_shift <= w_shift;
            r_cur   <= w_cur;
            r_last  <= w_last;
            r_bcnt  <= w_bcnt;
            r_ones  <= w_ones;
            r_pend  <= w_pend;
            r_prev  <= w_prev;
            r_raw   <= w_raw;
            r_stuff <= w_stuff;
            r_wd    <= w_wd;
            r_ur    <= w_ur;
            if (w_load) begin
                r_hold      <= tx.tx_data;
                r_hold_last <= tx.tx_last;
                r_hold_v    <= 1'b1;
            end else if (w_fetch) begin
                r_hold_v <= 1'b0;
            end
        end
    end

    usb_nrzi_enc #(
        .BYPASS (NRZI_EN == 0)
    ) u_nrzi (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_emit),
        .i_bit  (w_raw),
        .o_line (serial_out)
    );

    assign tx.tx_ready    = !r_hold_v;
    assign raw_bit        = r_raw;
    assign stuff_active   = r_stuff;
    assign busy           = (r_state != IDLE);
    assign word_done      = r_wd;
    assign underrun       = r_ur;
    assign prev_parallel  = r_prev;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Directed bench: default 8-bit NRZI instance plus a 16-bit
// MSB-first raw-line instance with a stuff limit of 3.
module tb_usb_tx_serializer;
    import usb_tx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_b = 1'b1;
    logic stb = 1'b0;
    logic stb_b = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic line_a = 1'b1;
    logic line_b = 1'b1;

    always #5 clk = ~clk;

    usb_tx_if #(.DATA_WIDTH(8))  a_if ();
    usb_tx_if #(.DATA_WIDTH(16)) b_if ();

    logic        a_ser, a_raw, a_st, a_busy, a_wd, a_ur;
    logic [7:0]  a_prev;
    logic        b_ser, b_raw, b_st, b_busy, b_wd, b_ur;
    logic [15:0] b_prev;

    usb_tx_serializer #(
        .DATA_WIDTH(8), .STUFF_LIMIT(6),
        .LSB_FIRST(1), .NRZI_EN(1)
    ) dut_a (
        .clk(clk), .rst(rst), .bit_strobe(stb), .tx(a_if),
        .serial_out(a_ser), .raw_bit(a_raw),
        .stuff_active(a_st), .busy(a_busy),
        .word_done(a_wd), .underrun(a_ur),
        .prev_parallel(a_prev)
    );

    usb_tx_serializer #(
        .DATA_WIDTH(16), .STUFF_LIMIT(3),
        .LSB_FIRST(0), .NRZI_EN(0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .bit_strobe(stb_b), .tx(b_if),
        .serial_out(b_ser), .raw_bit(b_raw),
        .stuff_active(b_st), .busy(b_busy),
        .word_done(b_wd), .underrun(b_ur),
        .prev_parallel(b_prev)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit sel, input logic [15:0] d,
                        input bit l);
        @(negedge clk);
        if (sel) begin
            b_if.tx_data = d; b_if.tx_last = l; b_if.tx_valid = 1'b1;
        end else begin
            a_if.tx_data = d[7:0]; a_if.tx_last = l;
            a_if.tx_valid = 1'b1;
        end
        @(negedge clk);
        a_if.tx_valid = 1'b0;
        b_if.tx_valid = 1'b0;
        chk("push_rdy", sel ? b_if.tx_ready : a_if.tx_ready, 0);
    endtask

    // Fetch strobe from IDLE: no bit goes out, hold is emptied.
    task automatic kick(input bit sel);
        @(negedge clk);
        if (sel) stb_b = 1'b1; else stb = 1'b1;
        @(negedge clk);
        stb = 1'b0; stb_b = 1'b0;
        chk("kick_busy", sel ? b_busy : a_busy, 1);
        chk("kick_rdy", sel ? b_if.tx_ready : a_if.tx_ready, 1);
    endtask

    task automatic run(input bit sel, input string tag, input int n,
                       input logic [31:0] r, input logic [31:0] s,
                       input logic [31:0] w, input logic [31:0] u);
        logic [4:0] obs, exp;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sel) stb_b = 1'b1; else stb = 1'b1;
            @(negedge clk);
            stb = 1'b0; stb_b = 1'b0;
            if (sel) begin
                line_b = r[i];
                obs = {b_raw, b_st, b_ser, b_wd, b_ur};
                exp = {r[i], s[i], line_b, w[i], u[i]};
            end else begin
                line_a = r[i] ? line_a : ~line_a;
                obs = {a_raw, a_st, a_ser, a_wd, a_ur};
                exp = {r[i], s[i], line_a, w[i], u[i]};
            end
            chk($sformatf("%s[%0d]", tag, i), 32'(obs), 32'(exp));
        end
    endtask

    initial begin
        a_if.tx_valid = 1'b0; a_if.tx_data = '0; a_if.tx_last = 1'b0;
        b_if.tx_valid = 1'b0; b_if.tx_data = '0; b_if.tx_last = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ser", a_ser, 1);
        chk("rst_raw", a_raw, 1);
        chk("rst_flags", {a_st, a_busy, a_wd, a_ur}, 0);
        chk("rst_rdy", a_if.tx_ready, 1);
        chk("rst_prev", a_prev, 0);
        chk("rst_b_ser", b_ser, 1);
        rst = 1'b0;
        rst_b = 1'b0;

        run(0, "idle", 10, 32'h3FF, 0, 0, 0);
        chk("idle_busy", a_busy, 0);
        chk("idle_rdy", a_if.tx_ready, 1);

        push(0, 16'h80, 1);
        kick(0);
        run(0, "w80", 8, 32'h80, 0, 32'h80, 0);
        chk("w80_prev", a_prev, 8'h80);
        chk("w80_busy", a_busy, 0);

        push(0, 16'hFC, 0);
        kick(0);
        push(0, 16'h03, 1);
        run(0, "fc03", 17, 32'h6FC, 32'h100, 32'h10100, 0);
        chk("fc03_prev", a_prev, 8'h03);
        chk("fc03_busy", a_busy, 0);
        chk("fc03_rdy", a_if.tx_ready, 1);

        push(0, 16'hFF, 1);
        kick(0);
        run(0, "ff", 9, 32'h1BF, 32'h040, 32'h100, 0);
        chk("ff_prev", a_prev, 8'hFF);
        chk("ff_busy", a_busy, 0);

        push(0, 16'hFC, 1);
        kick(0);
        run(0, "tail", 9, 32'h0FC, 32'h100, 32'h100, 0);
        chk("tail_prev", a_prev, 8'hFC);
        chk("tail_busy", a_busy, 0);

        push(0, 16'h55, 0);
        kick(0);
        push(0, 16'hAA, 0);
        chk("b2b_busy", a_busy, 1);
        run(0, "w55", 8, 32'h55, 0, 32'h80, 0);
        chk("w55_rdy", a_if.tx_ready, 1);
        push(0, 16'h0F, 0);
        run(0, "wAA", 8, 32'hAA, 0, 32'h80, 0);
        chk("wAA_prev", a_prev, 8'hAA);
        run(0, "w0F", 8, 32'h0F, 0, 32'h80, 32'h80);
        chk("ur_busy", a_busy, 0);
        @(negedge clk);
        chk("ur_clr", {a_wd, a_ur}, 0);

        push(1, 16'hF000, 1);
        kick(1);
        run(1, "b16", 17, 32'h17, 32'h08, 32'h10000, 0);
        chk("b16_prev", b_prev, 16'hF000);
        chk("b16_busy", b_busy, 0);

        push(1, 16'h0F00, 0);
        kick(1);
        run(1, "bmid", 2, 0, 0, 0, 0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        chk("bmid_ser", b_ser, 1);
        chk("bmid_raw", b_raw, 1);
        chk("bmid_busy", b_busy, 0);
        chk("bmid_rdy", b_if.tx_ready, 1);
        rst_b = 1'b0;
        @(negedge clk);
        stb_b = 1'b1;
        @(negedge clk);
        stb_b = 1'b0;
        chk("bmid_drop", {b_busy, b_ser}, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
